// File: rtl/inst_load_ctrl.sv
// Boot-time instruction loader: packs UART bytes MSB-first into words,
// writes them to the instruction BRAM and releases the core on END_WORD.
module inst_load_ctrl #(
    parameter int          INST_SIZE = 10,
    parameter logic [31:0] END_WORD  = 32'h0000_003F,
    parameter int          TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [INST_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_din,
    output logic                 mem_we,
    output logic [1:0]           mode,
    output logic                 done,
    output logic [INST_SIZE:0]   word_count,
    output logic                 overflow
);

    localparam int CW = INST_SIZE + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_WORDS = {1'b1, {INST_SIZE{1'b0}}};
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [23:0]          sh_q, sh_d;
    logic [TW-1:0]        to_q, to_d;
    logic [CW-1:0]        word_count_q, word_count_d;
    logic [INST_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]          mem_din_q, mem_din_d;
    logic                 mem_we_q, mem_we_d;
    logic                 overflow_q, overflow_d;
    logic                 term_q, term_d;
    logic [31:0]          word;

    assign word = {sh_q, rx_data};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        sh_d         = sh_q;
        to_d         = to_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        overflow_d   = overflow_q;
        term_d       = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    byte_cnt_d   = '0;
                    sh_d         = '0;
                    to_d         = '0;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                    overflow_d   = 1'b0;
                end
            end
            S_LOAD: begin
                // terminator was written this cycle; hand over to the core
                if (term_q) begin
                    state_d = S_DONE;
                end else if (rx_valid) begin
                    to_d       = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    sh_d       = {sh_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        if (word_count_q == MAX_WORDS) begin
                            overflow_d = 1'b1;
                            state_d    = S_ERR;
                        end else begin
                            mem_we_d     = 1'b1;
                            mem_din_d    = word;
                            mem_addr_d   = word_count_q[INST_SIZE-1:0];
                            word_count_d = word_count_q + CW'(1);
                            term_d       = (word == END_WORD);
                        end
                    end
                end else if (byte_cnt_q != 2'd0) begin
                    if (to_q == TO_LAST) begin
                        to_d       = '0;
                        byte_cnt_d = '0;
                        sh_d       = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            sh_q         <= '0;
            to_q         <= '0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            overflow_q   <= 1'b0;
            term_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            sh_q         <= sh_d;
            to_q         <= to_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            overflow_q   <= overflow_d;
            term_q       <= term_d;
        end
    end

    always_comb begin
        mode = 2'd0;
        unique case (state_q)
            S_LOAD:  mode = 2'd1;
            S_DONE:  mode = 2'd2;
            default: mode = 2'd0;
        endcase
    end

    assign done       = (state_q == S_DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Bench for inst_load_ctrl: directed scenarios plus randomized loads
// compared against a word-level model of the loader.
module tb_inst_load_ctrl;

    localparam int          IS  = 2;
    localparam int          TO  = 30;
    localparam logic [31:0] END = 32'h0000_003F;
    localparam int          MAXW = 1 << IS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [IS-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic          mem_we;
    logic [1:0]    mode;
    logic          done;
    logic [IS:0]   word_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int          wa[$];
    logic [31:0] wd[$];

    inst_load_ctrl #(
        .INST_SIZE(IS),
        .END_WORD (END),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mode      (mode),
        .done      (done),
        .word_count(word_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(mem_din);
        end
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) put(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(1);
        #1;
        wa.delete();
        wd.delete();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_din, mem_we, mode, done, word_count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_init: got we=%b mode=%0d done=%b wc=%0d ovf=%b addr=%0d din=%h, need all zero",
                     mem_we, mode, done, word_count, overflow, mem_addr, mem_din);
        end
        do_reset();
        pulse_start();
        put_word(32'h1111_0001);
        put_word(32'h2222_0002);
        put(8'h55);
        idle(2);
        #1;
        checks++;
        if (int'(word_count) !== 2 || wa.size() !== 2) begin
            errors++;
            $display("FAIL reset_preload: got wc=%0d writes=%0d, need 2 and 2", word_count, wa.size());
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_din, mem_we, mode, done, word_count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_async: got we=%b mode=%0d done=%b wc=%0d ovf=%b addr=%0d din=%h, need all zero",
                     mem_we, mode, done, word_count, overflow, mem_addr, mem_din);
        end
        idle(1);
        rstn = 1'b1;
        put_word(END);
        idle(3);
        #1;
        checks++;
        if (wa.size() !== 2 || mode !== 2'd0 || int'(word_count) !== 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignore_rx: got writes=%0d mode=%0d wc=%0d done=%b, need 2 0 0 0",
                     wa.size(), mode, word_count, done);
        end
    endtask

    task automatic test_basic;
        do_reset();
        pulse_start();
        #1;
        checks++;
        if (mode !== 2'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: got mode=%0d done=%b, need 1 0", mode, done);
        end
        put_word(32'h1);
        put_word(32'h2);
        put(8'h00); put(8'h00); put(8'h00); put(8'h3F);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b1 || int'(mem_addr) !== 2 || mem_din !== END || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_term_write: got we=%b addr=%0d din=%h done=%b, need 1 2 0000003f 0",
                     mem_we, mem_addr, mem_din, done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || mode !== 2'd2 || mem_we !== 1'b0 || int'(word_count) !== 3) begin
            errors++;
            $display("FAIL basic_done: got done=%b mode=%0d we=%b wc=%0d, need 1 2 0 3",
                     done, mode, mem_we, word_count);
        end
        checks++;
        if (wa.size() !== 3 || wa[0] !== 0 || wa[1] !== 1 || wa[2] !== 2 ||
            wd[0] !== 32'h1 || wd[1] !== 32'h2 || wd[2] !== END) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes, need addr 0,1,2 data 1,2,3f", wa.size());
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        pulse_start();
        put(8'h12); put(8'h34); put(8'h56); put(8'h78);
        put(8'h9A);
        #1;
        checks++;
        if (mem_we !== 1'b1 || int'(mem_addr) !== 0 || mem_din !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_word0: got we=%b addr=%0d din=%h, need 1 0 12345678",
                     mem_we, mem_addr, mem_din);
        end
        put(8'hBC); put(8'hDE); put(8'hF0);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b1 || int'(mem_addr) !== 1 || mem_din !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL b2b_word1: got we=%b addr=%0d din=%h, need 1 1 9abcdef0",
                     mem_we, mem_addr, mem_din);
        end
        idle(2);
        #1;
        checks++;
        if (wa.size() !== 2 || mode !== 2'd1 || int'(word_count) !== 2) begin
            errors++;
            $display("FAIL b2b_after: got writes=%0d mode=%0d wc=%0d, need 2 1 2", wa.size(), mode, word_count);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        pulse_start();
        put(8'hAA);
        put(8'hBB);
        idle(TO + 2);
        put_word(END);
        idle(2);
        #1;
        checks++;
        if (wa.size() !== 1 || done !== 1'b1 || int'(word_count) !== 1) begin
            errors++;
            $display("FAIL timeout_count: got writes=%0d done=%b wc=%0d, need 1 1 1", wa.size(), done, word_count);
        end else begin
            checks++;
            if (wa[0] !== 0 || wd[0] !== END) begin
                errors++;
                $display("FAIL timeout_data: got addr=%0d din=%h, need 0 0000003f", wa[0], wd[0]);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset();
        pulse_start();
        for (int i = 0; i < MAXW + 1; i++) put_word(32'hA500_0100 + 32'(i));
        idle(2);
        #1;
        checks++;
        if (overflow !== 1'b1 || mode !== 2'd0 || done !== 1'b0 || int'(word_count) !== MAXW) begin
            errors++;
            $display("FAIL ovf_flags: got ovf=%b mode=%0d done=%b wc=%0d, need 1 0 0 %0d",
                     overflow, mode, done, word_count, MAXW);
        end
        checks++;
        if (wa.size() !== MAXW) begin
            errors++;
            $display("FAIL ovf_writes: got %0d writes, need %0d", wa.size(), MAXW);
        end else begin
            for (int i = 0; i < MAXW; i++) begin
                checks++;
                if (wa[i] !== i || wd[i] !== 32'hA500_0100 + 32'(i)) begin
                    errors++;
                    $display("FAIL ovf_write%0d: got addr=%0d din=%h, need %0d %h",
                             i, wa[i], wd[i], i, 32'hA500_0100 + 32'(i));
                end
            end
        end
        pulse_start();
        #1;
        checks++;
        if (overflow !== 1'b0 || mode !== 2'd1) begin
            errors++;
            $display("FAIL ovf_restart: got ovf=%b mode=%0d, need 0 1", overflow, mode);
        end
        wa.delete();
        wd.delete();
        for (int i = 0; i < MAXW; i++) put_word(32'h0000_1000 + 32'(i));
        put_word(END);
        idle(2);
        #1;
        checks++;
        if (wa.size() !== MAXW || wa[0] !== 0 || overflow !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_late_term: got writes=%0d ovf=%b done=%b, need %0d 1 0",
                     wa.size(), overflow, done, MAXW);
        end
        pulse_start();
        wa.delete();
        wd.delete();
        put_word(END);
        idle(2);
        #1;
        checks++;
        if (wa.size() !== 1 || wa[0] !== 0 || done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reload: got writes=%0d done=%b ovf=%b, need 1 1 0", wa.size(), done, overflow);
        end
    endtask

    task automatic test_done_ignore;
        int n;
        do_reset();
        pulse_start();
        put_word(32'h7);
        put_word(END);
        idle(2);
        #1;
        n = wa.size();
        put_word(END);
        idle(2);
        #1;
        checks++;
        if (wa.size() !== n || n !== 2 || done !== 1'b1 || int'(word_count) !== 2) begin
            errors++;
            $display("FAIL done_ignore: got writes=%0d/%0d done=%b wc=%0d, need 2/2 1 2",
                     n, wa.size(), done, word_count);
        end
        pulse_start();
        #1;
        checks++;
        if (done !== 1'b0 || mode !== 2'd1) begin
            errors++;
            $display("FAIL done_restart: got done=%b mode=%0d, need 0 1", done, mode);
        end
        put_word(32'hCAFE_0001);
        idle(1);
        #1;
        checks++;
        if (wa.size() !== 3 || wa[2] !== 0 || wd[2] !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL done_reload_write: got writes=%0d, need 3 with last at addr 0 data cafe0001", wa.size());
        end
    endtask

    task automatic test_random;
        logic [31:0] words[$];
        int          ea[$];
        logic [31:0] ed[$];
        int          n;
        int          term;
        logic        e_done;
        logic        e_ovf;
        logic [1:0]  e_mode;
        logic [31:0] w;
        for (int it = 0; it < 24; it++) begin
            do_reset();
            words.delete();
            ea.delete();
            ed.delete();
            n    = $urandom_range(1, MAXW + 2);
            term = $urandom_range(0, 1);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == END) w = w ^ 32'h1;
                if (term == 1 && i == n - 1) w = END;
                words.push_back(w);
            end
            e_done = 1'b0;
            e_ovf  = 1'b0;
            foreach (words[i]) begin
                if (ea.size() == MAXW) begin
                    e_ovf = 1'b1;
                    break;
                end
                ea.push_back(ea.size());
                ed.push_back(words[i]);
                if (words[i] == END) begin
                    e_done = 1'b1;
                    break;
                end
            end
            e_mode = e_done ? 2'd2 : (e_ovf ? 2'd0 : 2'd1);
            pulse_start();
            foreach (words[i]) begin
                for (int b = 3; b >= 0; b--) begin
                    put(words[i][8*b +: 8]);
                    idle($urandom_range(0, 3));
                end
            end
            idle(3);
            #1;
            checks++;
            if (done !== e_done || overflow !== e_ovf || mode !== e_mode ||
                int'(word_count) !== ea.size() || wa.size() !== ea.size()) begin
                errors++;
                $display("FAIL rand%0d_state: got done=%b ovf=%b mode=%0d wc=%0d writes=%0d, need %b %b %0d %0d %0d",
                         it, done, overflow, mode, word_count, wa.size(),
                         e_done, e_ovf, e_mode, ea.size(), ea.size());
            end else begin
                foreach (ea[i]) begin
                    checks++;
                    if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got addr=%0d din=%h, need %0d %h",
                                 it, i, wa[i], wd[i], ea[i], ed[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_done_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
